mips_pipe_hazard_ctrl: RTL and testbench
========================================

// Module: mips_pipe_hazard_ctrl
// PURPOSE
//  Hazard and forwarding controller for the 5-stage pipelined MIPS core (IF/ID/EX/MEM/WB).
//  Tracks destination tags of in-flight instructions and generates stall, flush and forwarding selects.
//  Times the multi-cycle mul/div unit and holds HI/LO readers and further mul/div instructions while it is busy.
//  Sits beside the Pc, Register, Alu and Memory datapaths. Replaces the implicit no-hazard control of the single-cycle top.
// PARAMETERS
//  REG_W      5  register index width; register 0 is hardwired zero
//  MD_LAT     4  mul/div latency in cycles, >=1; MD_LAT=1 means never busy
//  ENABLE_FWD 1  1 = forward from MEM/WB; 0 = stall on every RAW hazard
// PORTS
//  ctrl        input  `Data_Control_Control_W  clock/reset bundle; one clock; reset synchronous, active-low
//  id_valid    input  1      ID holds a real instruction
//  id_rs       input  REG_W  ID source register 1
//  id_rt       input  REG_W  ID source register 2
//  id_useRs    input  1      ID reads rs
//  id_useRt    input  1      ID reads rt
//  id_dest     input  REG_W  ID destination register
//  id_regWrite input  1      ID writes the register file
//  id_memRead  input  1      ID is a load
//  id_isMulDiv input  1      ID is mult/multu/div/divu
//  id_readHiLo input  1      ID is mfhi/mflo
//  id_redirect input  1      branch/jump taken, resolved in ID
//  stallF      output 1      hold PC
//  stallD      output 1      hold the IF/ID register
//  flushD      output 1      kill the IF/ID register next edge
//  bubbleE     output 1      load a NOP into ID/EX next edge
//  fwdA        output 2      EX operand A select (`Mips_Type_FwdSel`)
//  fwdB        output 2      EX operand B select
//  mdBusy      output 1      mul/div in progress
// BEHAVIOUR
//  - State: tag records {valid,dest,regWrite,memRead} for the EX, MEM and WB stages, plus the mul/div down-counter.
//  - All outputs are combinational from the state and ID inputs.
//  - Reset (ctrl reset low at a rising edge) clears all valid bits and the counter. Every output is 0 in the following cycle.
//  - A reset mid-operation discards in-flight tags and aborts any mul/div count.
//  - Each edge: WB<=MEM, MEM<=EX, EX<=ID tag. If bubbleE, EX<=invalid.
//  - An ID tag is valid only when id_valid=1 and stallD=0.
//  - Forwarding (ENABLE_FWD=1) applies to the current EX instruction's sources.
//    - Source s is compared against the MEM tag first, then the WB tag (nearest wins).
//    - A match requires valid, regWrite=1, dest==s and s!=0.
//    - Encodings: FWD_MEM=1, FWD_WB=2, otherwise FWD_REG=0.
//    - With ENABLE_FWD=0, fwdA=fwdB=0 always.
//  - hazRAW (ENABLE_FWD=1): the EX tag is a load, its dest!=0, and its dest matches a used ID source. This is a load-use stall of exactly 1 cycle.
//  - hazRAW (ENABLE_FWD=0): any valid regWrite tag in EX/MEM/WB matches a used ID source with dest!=0.
//  - hazMD: id_valid & (id_isMulDiv|id_readHiLo) & mdBusy.
//  - stall = id_valid & (hazRAW|hazMD); stallF=stallD=bubbleE=stall.
//  - flushD = id_redirect & ~stall. Stall has priority: a redirect from a stalled branch is re-evaluated next cycle.
//  - Mul/div counter:
//    - On an unstalled ID mul/div issue, load MD_LAT-1. Otherwise decrement while nonzero.
//    - mdBusy = counter!=0.
//    - The counter width is clog2(MD_LAT) with a minimum of 1. It never wraps below 0.
//  - Simultaneous counter reaching 0 and an ID HI/LO read: mdBusy is already 0 that cycle, so there is no stall.
// STRUCTURE
//  - Shared package Mips/Type/FwdSel.v: `Mips_Type_FwdSel_T, FWD_REG/FWD_MEM/FWD_WB constants.
//  - Shared package Mips/Type/PipeTag.v: `Mips_Type_PipeTag_T record macro {valid,dest,regWrite,memRead}.
//  - Sub-module mips_muldiv_timer (parameter MD_LAT; ports ctrl, start, busy) holds the counter.
//  - Tag pipeline and compare logic stay in this module.
// TESTING
//  - Reset held 2 cycles with random inputs -> all outputs 0; after release, no stall with id_valid=0.
//  - add $3 then add $4,$3,$3 -> the second instruction in EX sees fwdA=fwdB=1; no stall.
//  - add $3, nop, sub $5,$3,$0 -> fwdA=2 in sub's EX cycle.
//  - lw $2 then add $6,$2,$1 -> stallF=stallD=bubbleE=1 for exactly 1 cycle, then fwdA=2.
//  - Writes to $0 followed by a use of $0 -> no stall and fwd=0, in both ENABLE_FWD settings.
//  - MD_LAT=4: mult, then mfhi next -> stall 3 cycles, mdBusy 1,1,1,0.
//  - In the same case, id_redirect during the stall -> flushD=0 until the stall clears.
//  - Reset asserted mid-count -> mdBusy=0 next cycle.

Source files
------------

// File: rtl/mips_pipe_hazard_pkg.sv
// Shared types for the pipelined MIPS hazard controller: clock/reset bundle,
// forwarding select encoding and mul/div counter sizing.
package mips_pipe_hazard_pkg;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // Counter width for a given latency; never narrower than one bit.
    function automatic int unsigned md_cnt_w(input int unsigned lat);
        return (lat <= 32'd2) ? 32'd1 : 32'($clog2(lat));
    endfunction

endpackage

// File: rtl/mips_pipe_hazard_ctrl_timer.sv
// Mul/div latency timer: loads MD_LAT-1 on issue and counts down to zero.
module mips_muldiv_timer
    import mips_pipe_hazard_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  ctrl_t ctrl,
    input  logic  start,
    output logic  busy
);

    localparam int unsigned CNT_W = md_cnt_w(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ctrl.clk) begin
        if (!ctrl.rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/mips_pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: tracks EX/MEM/WB
// destination tags, raises load-use and mul/div stalls, and selects EX bypasses.
module mips_pipe_hazard_ctrl
    import mips_pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MD_LAT     = 4,
    parameter int unsigned ENABLE_FWD = 1
) (
    input  ctrl_t            ctrl,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_useRs,
    input  logic             id_useRt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_isMulDiv,
    input  logic             id_readHiLo,
    input  logic             id_redirect,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             bubbleE,
    output fwd_sel_t         fwdA,
    output fwd_sel_t         fwdB,
    output logic             mdBusy
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             regWrite;
        logic             memRead;
    } pipe_tag_t;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             useRs;
        logic             useRt;
    } ex_src_t;

    pipe_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    ex_src_t   src_q, src_d;
    logic      haz_raw, haz_md, stall, md_busy, md_start;
    logic      unused_wb_mem_read;

    function automatic logic tag_hit(input pipe_tag_t t, input logic [REG_W-1:0] s,
                                     input logic used);
        return used & t.valid & t.regWrite & (t.dest == s) & (s != '0);
    endfunction

    // Nearest producer wins: MEM is younger than WB.
    function automatic fwd_sel_t fwd_pick(input logic [REG_W-1:0] s, input logic used);
        fwd_sel_t sel;
        sel = FWD_REG;
        if (ENABLE_FWD != 0 && ex_q.valid) begin
            if (tag_hit(mem_q, s, used)) begin
                sel = FWD_MEM;
            end else if (tag_hit(wb_q, s, used)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        haz_raw = 1'b0;
        if (ENABLE_FWD != 0) begin
            haz_raw = ex_q.valid & ex_q.memRead & (ex_q.dest != '0)
                    & ((id_useRs & (ex_q.dest == id_rs)) | (id_useRt & (ex_q.dest == id_rt)));
        end else begin
            haz_raw = tag_hit(ex_q,  id_rs, id_useRs) | tag_hit(ex_q,  id_rt, id_useRt)
                    | tag_hit(mem_q, id_rs, id_useRs) | tag_hit(mem_q, id_rt, id_useRt)
                    | tag_hit(wb_q,  id_rs, id_useRs) | tag_hit(wb_q,  id_rt, id_useRt);
        end
        haz_md   = (id_isMulDiv | id_readHiLo) & md_busy;
        stall    = ctrl.rst_n & id_valid & (haz_raw | haz_md);
        md_start = id_valid & id_isMulDiv & ~stall;
    end

    mips_muldiv_timer #(
        .MD_LAT(MD_LAT)
    ) u_md_timer (
        .ctrl (ctrl),
        .start(md_start),
        .busy (md_busy)
    );

    // A stalled ID stage sends a bubble into EX instead of its own tag.
    always_comb begin
        ex_d.valid    = id_valid & ~stall;
        ex_d.dest     = id_dest;
        ex_d.regWrite = id_regWrite;
        ex_d.memRead  = id_memRead;
        src_d.rs      = id_rs;
        src_d.rt      = id_rt;
        src_d.useRs   = id_useRs;
        src_d.useRt   = id_useRt;
        mem_d         = ex_q;
        wb_d          = mem_q;
    end

    always_ff @(posedge ctrl.clk) begin
        if (!ctrl.rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            src_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            src_q <= src_d;
        end
    end

    always_comb begin
        stallF  = stall;
        stallD  = stall;
        bubbleE = stall;
        flushD  = ctrl.rst_n & id_redirect & ~stall;
        mdBusy  = ctrl.rst_n & md_busy;
        fwdA    = ctrl.rst_n ? fwd_pick(src_q.rs, src_q.useRs) : FWD_REG;
        fwdB    = ctrl.rst_n ? fwd_pick(src_q.rt, src_q.useRt) : FWD_REG;
    end

    assign unused_wb_mem_read = wb_q.memRead;

endmodule

// File: tb/tb_mips_pipe_hazard_ctrl.sv
// Directed bench for mips_pipe_hazard_ctrl: forwarding and non-forwarding
// instances share one instruction stream with hand-computed expectations.
module tb_mips_pipe_hazard_ctrl;
    import mips_pipe_hazard_pkg::*;

    logic       clk;
    logic       rst_n;
    ctrl_t      ctrl;
    logic       id_valid, id_useRs, id_useRt, id_regWrite, id_memRead;
    logic       id_isMulDiv, id_readHiLo, id_redirect;
    logic [4:0] id_rs, id_rt, id_dest;

    logic       stallF_f, stallD_f, flushD_f, bubbleE_f, mdBusy_f;
    logic       stallF_n, stallD_n, flushD_n, bubbleE_n, mdBusy_n;
    logic [1:0] fwdA_f, fwdB_f, fwdA_n, fwdB_n;
    logic [2:0] stl_f, stl_n;

    int errors = 0;
    int checks = 0;

    assign ctrl  = '{clk: clk, rst_n: rst_n};
    assign stl_f = {stallF_f, stallD_f, bubbleE_f};
    assign stl_n = {stallF_n, stallD_n, bubbleE_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_pipe_hazard_ctrl #(.REG_W(5), .MD_LAT(4), .ENABLE_FWD(1)) u_dut_fwd (
        .ctrl(ctrl), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_dest(id_dest),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_isMulDiv(id_isMulDiv), .id_readHiLo(id_readHiLo), .id_redirect(id_redirect),
        .stallF(stallF_f), .stallD(stallD_f), .flushD(flushD_f), .bubbleE(bubbleE_f),
        .fwdA(fwdA_f), .fwdB(fwdB_f), .mdBusy(mdBusy_f)
    );

    mips_pipe_hazard_ctrl #(.REG_W(5), .MD_LAT(4), .ENABLE_FWD(0)) u_dut_nofwd (
        .ctrl(ctrl), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_useRs(id_useRs), .id_useRt(id_useRt), .id_dest(id_dest),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_isMulDiv(id_isMulDiv), .id_readHiLo(id_readHiLo), .id_redirect(id_redirect),
        .stallF(stallF_n), .stallD(stallD_n), .flushD(flushD_n), .bubbleE(bubbleE_n),
        .fwdA(fwdA_n), .fwdB(fwdB_n), .mdBusy(mdBusy_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dest,
                          input logic rw, input logic mr, input logic md,
                          input logic hl, input logic rd);
        id_valid = v;     id_rs = rs;       id_rt = rt;
        id_useRs = urs;   id_useRt = urt;   id_dest = dest;
        id_regWrite = rw; id_memRead = mr;  id_isMulDiv = md;
        id_readHiLo = hl; id_redirect = rd;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_id();
        set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom));
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_f"}, 32'({stl_f, flushD_f, fwdA_f, fwdB_f, mdBusy_f}), 32'(0));
        check({tag, "_n"}, 32'({stl_n, flushD_n, fwdA_n, fwdB_n, mdBusy_n}), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        rand_id();

        // Reset held two cycles with random ID inputs.
        tick(); rand_id(); #1; check_all_zero("rst_c1");
        tick(); rand_id(); #1; check_all_zero("rst_c2");
        tick(); rst_n = 1'b1; idle(); #1;
        check_all_zero("post_rst_idle");

        // add $3 ; add $4,$3,$3 -> MEM bypass on both operands.
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0); #1;
        check("fwd_add1_stall", 32'(stl_f), 32'(0));
        tick(); set_id(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 0); #1;
        check("fwd_add2_stall", 32'(stl_f), 32'(0));
        check("nofwd_add2_stall", 32'(stl_n), 32'(7));
        tick(); idle(); #1;
        check("fwd_add2_fwdA", 32'(fwdA_f), 32'(1));
        check("fwd_add2_fwdB", 32'(fwdB_f), 32'(1));
        check("nofwd_add2_fwd", 32'({fwdA_n, fwdB_n}), 32'(0));
        drain();

        // add $3 ; nop ; sub $5,$3,$0 -> WB bypass on A only.
        tick(); set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0); #1;
        tick(); idle(); #1;
        tick(); set_id(1, 5'd3, 5'd0, 1, 1, 5'd5, 1, 0, 0, 0, 0); #1;
        check("fwd_sub_stall", 32'(stl_f), 32'(0));
        check("nofwd_sub_stall", 32'(stl_n), 32'(7));
        tick(); idle(); #1;
        check("fwd_sub_fwdA", 32'(fwdA_f), 32'(2));
        check("fwd_sub_fwdB", 32'(fwdB_f), 32'(0));
        drain();

        // lw $2 ; add $6,$2,$1 -> one-cycle load-use stall, then WB bypass.
        tick(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0, 0); #1;
        tick(); set_id(1, 5'd2, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 0); #1;
        check("lu_stall_c1", 32'(stl_f), 32'(7));
        tick(); #1;
        check("lu_stall_c2", 32'(stl_f), 32'(0));
        tick(); idle(); #1;
        check("lu_fwdA", 32'(fwdA_f), 32'(2));
        check("lu_fwdB", 32'(fwdB_f), 32'(0));
        drain();

        // lw $0 ; add $7,$0,$0 -> register zero never stalls nor forwards.
        tick(); set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 0); #1;
        tick(); set_id(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 0); #1;
        check("z0_stall_f", 32'(stl_f), 32'(0));
        check("z0_stall_n", 32'(stl_n), 32'(0));
        tick(); idle(); #1;
        check("z0_fwd_f", 32'({fwdA_f, fwdB_f}), 32'(0));
        check("z0_fwd_n", 32'({fwdA_n, fwdB_n}), 32'(0));
        drain();

        // mult ; mfhi held three cycles, redirect raised while stalled.
        tick(); set_id(1, 5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 1, 0, 0); #1;
        check("md_c0_busy", 32'(mdBusy_f), 32'(0));
        check("md_c0_stall", 32'(stl_f), 32'(0));
        tick(); set_id(1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 0, 1, 0); #1;
        check("md_c1_busy", 32'(mdBusy_f), 32'(1));
        check("md_c1_busy_n", 32'(mdBusy_n), 32'(1));
        check("md_c1_stall", 32'(stl_f), 32'(7));
        tick(); id_redirect = 1'b1; #1;
        check("md_c2_busy", 32'(mdBusy_f), 32'(1));
        check("md_c2_stall", 32'(stl_f), 32'(7));
        check("md_c2_flush", 32'(flushD_f), 32'(0));
        tick(); #1;
        check("md_c3_busy", 32'(mdBusy_f), 32'(1));
        check("md_c3_stall", 32'(stl_f), 32'(7));
        check("md_c3_flush", 32'(flushD_f), 32'(0));
        tick(); #1;
        check("md_c4_busy", 32'(mdBusy_f), 32'(0));
        check("md_c4_stall", 32'(stl_f), 32'(0));
        check("md_c4_flush", 32'(flushD_f), 32'(1));
        tick(); idle(); #1;
        check("md_c5_flush", 32'(flushD_f), 32'(0));
        drain();

        // Reset pulse mid-count aborts the mul/div timer.
        tick(); set_id(1, 5'd8, 5'd9, 1, 1, 5'd0, 0, 0, 1, 0, 0); #1;
        tick(); idle(); #1;
        check("mrst_busy_before", 32'(mdBusy_f), 32'(1));
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 0, 0, 1, 0); #1;
        check("mrst_busy_f", 32'(mdBusy_f), 32'(0));
        check("mrst_busy_n", 32'(mdBusy_n), 32'(0));
        check("mrst_stall_f", 32'(stl_f), 32'(0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
